// File: rtl/spi_flash_responder_if.sv
// SPI pins, preload port and status outputs of the SPI flash responder.
interface spi_flash_responder_if #(
    parameter int ADDR_BITS = 12
);
    logic                 spi_cs;
    logic                 spi_sclk;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic                 spi_miso_oe;
    logic                 ld_we;
    logic [ADDR_BITS-1:0] ld_adr;
    logic [7:0]           ld_dat;
    logic                 powered_down;
    logic                 selected;

    modport slave (
        input  spi_cs, spi_sclk, spi_mosi, ld_we, ld_adr, ld_dat,
        output spi_miso, spi_miso_oe, powered_down, selected
    );

    modport master (
        output spi_cs, spi_sclk, spi_mosi, ld_we, ld_adr, ld_dat,
        input  spi_miso, spi_miso_oe, powered_down, selected
    );
endinterface

// File: rtl/spi_flash_responder.sv
// Mode-3 SPI NOR flash emulator: READ, deep power-down and release from a preloadable byte array.
// Optional FAST READ (0x0B) when SPI_FLASH_RESPONDER_FAST_READ_EN is defined.
module spi_flash_responder #(
    parameter int ADDR_BITS   = 12,
    parameter bit PD_AT_RESET = 1'b1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    spi_flash_responder_if.slave    bus
);
    typedef enum logic [2:0] {S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE} state_t;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PD   = 8'hB9;
    localparam logic [7:0] OP_RES  = 8'hAB;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    localparam logic [7:0] OP_FAST = 8'h0B;
`endif
    localparam int SH_W = (ADDR_BITS - 1 > 7) ? ADDR_BITS - 1 : 7;

    logic [1:0]           cs_q;
    logic [2:0]           sclk_q;
    logic [1:0]           mosi_q;
    logic [1:0]           vld_q;
    state_t               state_q;
    logic [4:0]           bitcnt_q;
    logic [3:0]           tot_q;
    logic [SH_W-1:0]      sh_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 rd_req_q;
    logic [7:0]           rd_dat_q;
    logic                 pend_pd_q;
    logic                 pd_q;
    logic                 fast_q;
    logic                 wait_cs_q;
    logic                 miso_q;
    logic                 oe_q;
    logic                 sel_q;
    logic [7:0]           mem [2**ADDR_BITS];

    logic                 cs_hi;
    logic                 active;
    logic                 rise;
    logic                 fall;
    logic                 mosi_s;
    logic [7:0]           op;

    // vld_q masks the synchronizer reset values until real pin levels have arrived
    assign cs_hi  = vld_q[1] & cs_q[1];
    assign active = vld_q[1] & ~cs_q[1] & ~wait_cs_q;
    assign rise   = active &  sclk_q[1] & ~sclk_q[2];
    assign fall   = active & ~sclk_q[1] &  sclk_q[2];
    assign mosi_s = mosi_q[1];
    assign op     = {sh_q[6:0], mosi_s};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cs_q      <= 2'b11;
            sclk_q    <= 3'b111;
            mosi_q    <= 2'b00;
            vld_q     <= 2'b00;
            state_q   <= S_CMD;
            bitcnt_q  <= '0;
            tot_q     <= '0;
            sh_q      <= '0;
            addr_q    <= '0;
            rd_req_q  <= 1'b0;
            pend_pd_q <= 1'b0;
            pd_q      <= PD_AT_RESET;
            fast_q    <= 1'b0;
            wait_cs_q <= 1'b1;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            cs_q     <= {cs_q[0], bus.spi_cs};
            sclk_q   <= {sclk_q[1:0], bus.spi_sclk};
            mosi_q   <= {mosi_q[0], bus.spi_mosi};
            vld_q    <= {vld_q[0], 1'b1};
            sel_q    <= vld_q[1] & ~cs_q[1];
            rd_req_q <= 1'b0;
            if (cs_hi) begin
                // a pending power-down only takes effect if the frame was exactly the opcode
                if (pend_pd_q && tot_q == 4'd8) pd_q <= 1'b1;
                pend_pd_q <= 1'b0;
                wait_cs_q <= 1'b0;
                state_q   <= S_CMD;
                bitcnt_q  <= '0;
                tot_q     <= '0;
                fast_q    <= 1'b0;
                oe_q      <= 1'b0;
                miso_q    <= 1'b0;
            end else begin
                if (rise && tot_q != 4'hF) tot_q <= tot_q + 4'd1;
                case (state_q)
                    S_CMD: if (rise) begin
                        sh_q     <= {sh_q[SH_W-2:0], mosi_s};
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_q <= '0;
                            state_q  <= S_IGNORE;
                            if (op == OP_RES) pd_q <= 1'b0;
                            if (op == OP_PD) pend_pd_q <= 1'b1;
                            if (op == OP_READ && !pd_q) state_q <= S_ADDR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                            if (op == OP_FAST && !pd_q) begin
                                state_q <= S_ADDR;
                                fast_q  <= 1'b1;
                            end
`endif
                        end
                    end
                    S_ADDR: if (rise) begin
                        sh_q     <= {sh_q[SH_W-2:0], mosi_s};
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd23) begin
                            bitcnt_q <= '0;
                            addr_q   <= {sh_q[ADDR_BITS-2:0], mosi_s};
                            rd_req_q <= 1'b1;
                            state_q  <= fast_q ? S_DUMMY : S_DATA;
                        end
                    end
                    S_DUMMY: if (rise) begin
                        bitcnt_q <= bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_q <= '0;
                            state_q  <= S_DATA;
                        end
                    end
                    S_DATA: if (fall) begin
                        oe_q     <= 1'b1;
                        miso_q   <= rd_dat_q[~bitcnt_q[2:0]];
                        bitcnt_q <= bitcnt_q + 5'd1;
                        // prefetch the following byte long before its first falling edge
                        if (bitcnt_q[2:0] == 3'd7) begin
                            bitcnt_q <= '0;
                            addr_q   <= addr_q + 1'b1;
                            rd_req_q <= 1'b1;
                        end
                    end
                    S_IGNORE: oe_q <= 1'b0;
                    default:  state_q <= S_IGNORE;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (bus.ld_we) mem[bus.ld_adr] <= bus.ld_dat;
    end

    // separate read process: a same-cycle load to the same address yields the old byte
    always_ff @(posedge wb_clk_i) begin
        if (rd_req_q) rd_dat_q <= mem[addr_q];
    end

    assign bus.spi_miso     = miso_q;
    assign bus.spi_miso_oe  = oe_q;
    assign bus.powered_down = pd_q;
    assign bus.selected     = sel_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master, array/power-state model and per-bit compare.
`timescale 1ns/1ps
module tb_spi_flash_responder;
    localparam int AB    = 12;
    localparam int MEMSZ = 1 << AB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_flash_responder_if #(.ADDR_BITS(AB)) bus();

    spi_flash_responder #(.ADDR_BITS(AB), .PD_AT_RESET(1'b1)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mem_m [MEMSZ];
    bit          pd_m;
    logic [63:0] got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int adr, input logic [7:0] dat);
        bus.ld_we  = 1'b1;
        bus.ld_adr = adr[AB-1:0];
        bus.ld_dat = dat;
        wclk(1);
        bus.ld_we  = 1'b0;
        mem_m[adr] = dat;
    endtask

    // Expected {oe, miso} just before rising edge k (1-based) of a frame.
    function automatic logic [1:0] exp_pin(input logic [7:0] op, input logic [23:0] a24,
                                           input int k, input bit pd);
        int start = 0;
        int idx;
        int unsigned a;
        if (op == 8'h03 && !pd) start = 33;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        if (op == 8'h0B && !pd) start = 41;
`endif
        if (start == 0 || k < start) return 2'b00;
        idx = k - start;
        a   = (int'(a24) + idx / 8) % MEMSZ;
        return {1'b1, mem_m[a][7 - idx % 8]};
    endfunction

    task automatic xfer(input logic [63:0] bits, input int nbits, input string tag);
        logic [7:0]  op  = bits[63:56];
        logic [23:0] a24 = bits[55:32];
        bit          pd0 = pd_m;
        logic [1:0]  e;
        bus.spi_cs = 1'b0;
        wclk(6);
        chk({tag, ".sel"}, 64'(bus.selected), 64'd1);
        for (int k = 1; k <= nbits; k++) begin
            bus.spi_sclk = 1'b0;
            bus.spi_mosi = bits[64 - k];
            wclk(6);
            e = exp_pin(op, a24, k, pd0);
            chk($sformatf("%s.oe%0d", tag, k), 64'(bus.spi_miso_oe), 64'(e[1]));
            chk($sformatf("%s.miso%0d", tag, k), 64'(bus.spi_miso), 64'(e[0]));
            got = {got[62:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            wclk(6);
        end
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        wclk(3);
        chk({tag, ".oe_drop"}, 64'(bus.spi_miso_oe), 64'd0);
        wclk(3);
        chk({tag, ".desel"}, 64'(bus.selected), 64'd0);
        if (nbits >= 8 && op == 8'hAB) pd_m = 1'b0;
        if (nbits == 8 && op == 8'hB9) pd_m = 1'b1;
        chk({tag, ".pd"}, 64'(bus.powered_down), 64'(pd_m));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fast_exp;
        bus.spi_cs   = 1'b1;
        bus.spi_sclk = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.ld_we    = 1'b0;
        bus.ld_adr   = '0;
        bus.ld_dat   = '0;
        got          = '0;
        pd_m         = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst.oe",   64'(bus.spi_miso_oe),  64'd0);
        chk("rst.miso", 64'(bus.spi_miso),     64'd0);
        chk("rst.sel",  64'(bus.selected),     64'd0);
        chk("rst.pd",   64'(bus.powered_down), 64'd1);
        wclk(3);
        rst_n = 1'b1;
        wclk(4);

        for (int i = 0; i < MEMSZ; i++) load(i, 8'((i * 37 + 5) & 8'hFF));
        load(12'h000, 8'h11); load(12'h001, 8'h22); load(12'h002, 8'h33); load(12'h003, 8'h44);
        load(12'hFFF, 8'hA5); load(12'h010, 8'h96); load(12'h020, 8'hC3);

        // asleep: READ is ignored
        xfer({8'h03, 24'h000000, 32'h0}, 64, "pdread");
        chk("pdread.word", got[31:0], 64'h0);
        chk("pdread.pd", 64'(bus.powered_down), 64'd1);

        xfer({8'hAB, 56'h0}, 8, "res1");
        chk("res1.pd", 64'(bus.powered_down), 64'd0);
        xfer({8'h03, 24'h000000, 32'h0}, 64, "read4");
        chk("read4.word", got[31:0], 64'h11223344);

        // alias above ADDR_BITS plus wrap 0xFFF -> 0x000
        load(12'h000, 8'h5A);
        xfer({8'h03, 24'h001FFF, 32'h0}, 48, "wrap");
        chk("wrap.bytes", got[15:0], 64'hA55A);

        xfer({8'hB9, 56'h0}, 7, "pd7");
        chk("pd7.pd", 64'(bus.powered_down), 64'd0);
        xfer({8'hB9, 56'h0}, 8, "pd8");
        chk("pd8.pd", 64'(bus.powered_down), 64'd1);
        xfer({8'hAB, 56'h0}, 8, "res2");

        xfer({8'h03, 24'h000000, 32'h0}, 35, "abort");
        xfer({8'h03, 24'h000010, 32'h0}, 40, "after_abort");
        chk("after_abort.byte", got[7:0], 64'h96);

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        fast_exp = 8'hC3;
`else
        fast_exp = 8'h00;
`endif
        xfer({8'h0B, 24'h000020, 32'h0}, 48, "fast");
        chk("fast.byte", got[7:0], 64'(fast_exp));

        // async reset in the middle of a READ data phase
        bus.spi_cs = 1'b0;
        wclk(6);
        for (int k = 1; k <= 36; k++) begin
            bus.spi_sclk = 1'b0;
            bus.spi_mosi = (k == 7 || k == 8) ? 1'b1 : 1'b0;
            wclk(6);
            bus.spi_sclk = 1'b1;
            wclk(6);
        end
        chk("arst.oe_before", 64'(bus.spi_miso_oe), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.oe",   64'(bus.spi_miso_oe),  64'd0);
        chk("arst.miso", 64'(bus.spi_miso),     64'd0);
        chk("arst.pd",   64'(bus.powered_down), 64'd1);
        wclk(2);
        rst_n = 1'b1;
        pd_m  = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            bus.spi_sclk = 1'b0;
            wclk(6);
            chk($sformatf("arst.tail_oe%0d", k), 64'(bus.spi_miso_oe), 64'd0);
            bus.spi_sclk = 1'b1;
            wclk(6);
        end
        bus.spi_cs = 1'b1;
        wclk(6);
        xfer({8'hAB, 56'h0}, 8, "res3");
        xfer({8'h03, 24'h000000, 32'h0}, 48, "recover");
        chk("recover.bytes", got[15:0], 64'h5A22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
